// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types and defaults for the APB master bridge
package apb_master_pkg;

    localparam int unsigned APB_MST_ADDR_WIDTH     = 12;
    localparam int unsigned APB_MST_DATA_WIDTH     = 32;
    localparam int unsigned APB_MST_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    typedef struct packed {
        logic                          write;
        logic [APB_MST_ADDR_WIDTH-1:0] addr;
        logic [APB_MST_DATA_WIDTH-1:0] wdata;
    } apb_mst_req_t;

    typedef struct packed {
        logic [APB_MST_DATA_WIDTH-1:0] rdata;
        logic                          err;
        logic                          timeout;
    } apb_mst_rsp_t;

endpackage

// File: rtl/apb_master_wdog.sv
// rtl/apb_master_wdog.sv - ACCESS wait-state counter for the optional transfer timeout
module apb_master_wdog
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = APB_MST_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Saturates at the limit so a late PREADY can never wrap it back to zero.
    always_ff @(posedge clk_i) begin
        if (!resetn_i || clear_i) begin
            cnt_q <= '0;
        end else if (count_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding valid/ready to APB initiator
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = APB_MST_ADDR_WIDTH,
    parameter int unsigned APB_DATA_WIDTH = APB_MST_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = APB_MST_TIMEOUT_CYCLES
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_mst_state_e            state_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rsp_valid_q;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                      rsp_err_q;
    logic                      rsp_timeout_q;
    logic                      timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    logic wdog_expired;

    apb_master_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i     (HCLK),
        .resetn_i  (HRESETn),
        .clear_i   (state_q == SETUP),
        .count_i   ((state_q == ACCESS) && !PREADY),
        .expired_o (wdog_expired)
    );

    assign timeout_hit = wdog_expired;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    // A new request may enter only when the response slot is free or draining this cycle.
    assign req_ready_o   = HRESETn && (state_q == IDLE) && (!rsp_valid_q || rsp_ready_i);

    assign PADDR         = paddr_q;
    assign PWDATA        = pwdata_q;
    assign PWRITE        = pwrite_q;
    assign PSEL          = psel_q;
    assign PENABLE       = penable_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q   <= 1'b0;
                rsp_rdata_q   <= '0;
                rsp_err_q     <= 1'b0;
                rsp_timeout_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        paddr_q   <= req_addr_i;
                        pwdata_q  <= req_wdata_i;
                        pwrite_q  <= req_write_i;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over an expiring timeout in the same cycle.
                    if (PREADY) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= IDLE;
                    end else if (timeout_hit) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
